// File: rtl/cmd_encoder_if.sv
// Request/link bundle for cmd_encoder: frame requests in, byte link and status out.
// The slave modport is the encoder side; master is the requester/receiver side.
interface cmd_encoder_if;
    logic [31:0] iCode;
    logic        iCode_Send;
    logic [7:0]  iIndex;
    logic        iIndex_Send;
    logic [7:0]  omData;
    logic        omData_Ready;
    logic        oBusy;
    logic        oDone;
    logic        oReject;

    modport slave (
        input  iCode, iCode_Send, iIndex, iIndex_Send,
        output omData, omData_Ready, oBusy, oDone, oReject
    );

    modport master (
        output iCode, iCode_Send, iIndex, iIndex_Send,
        input  omData, omData_Ready, oBusy, oDone, oReject
    );
endinterface

// File: rtl/cmd_encoder.sv
// Serialises code (5-byte) and index (2-byte) frames onto a strobed byte link.
// Optional macro CMD_ENCODER_PENDING_EN adds one pending slot per frame type.
module cmd_encoder #(
    parameter int SETUP_CYC = 1,
    parameter int STROBE_HI = 2,
    parameter int STROBE_LO = 2
) (
    input  logic          iClk,
    input  logic          iRst_n,
    cmd_encoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HIGH_LAST  = 8'(STROBE_HI - 1);
    localparam logic [7:0] LOW_LAST   = 8'(STROBE_LO - 1);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] code_q, code_d;
    logic [7:0]  index_q, index_d;
    logic        is_code_q, is_code_d;
    logic        done_q, done_d;
    logic        reject_q, reject_d;

    logic        start_go;
    logic        start_is_code;
    logic [31:0] start_code;
    logic [7:0]  start_index;
    logic        code_taken;
    logic        index_taken;

`ifdef CMD_ENCODER_PENDING_EN
    logic        pend_code_q, pend_code_d;
    logic [31:0] pend_code_val_q, pend_code_val_d;
    logic        pend_index_q, pend_index_d;
    logic [7:0]  pend_index_val_q, pend_index_val_d;
`endif

    function automatic logic [7:0] frame_byte(input logic is_code, input logic [2:0] idx,
                                              input logic [31:0] code, input logic [7:0] index);
        logic [7:0] b;
        if (is_code) begin
            case (idx)
                3'd0:    b = 8'h01;
                3'd1:    b = code[7:0];
                3'd2:    b = code[15:8];
                3'd3:    b = code[23:16];
                default: b = code[31:24];
            endcase
        end else begin
            b = (idx == 3'd0) ? 8'h02 : index;
        end
        return b;
    endfunction

    // Next-state logic; a frame start is resolved in IDLE and applied after the case so
    // that both fresh and pending requests share one load path.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        byte_d        = byte_q;
        data_d        = data_q;
        code_d        = code_q;
        index_d       = index_q;
        is_code_d     = is_code_q;
        done_d        = 1'b0;
        reject_d      = 1'b0;
        start_go      = 1'b0;
        start_is_code = 1'b0;
        start_code    = bus.iCode;
        start_index   = bus.iIndex;
        code_taken    = 1'b0;
        index_taken   = 1'b0;
`ifdef CMD_ENCODER_PENDING_EN
        pend_code_d      = pend_code_q;
        pend_code_val_d  = pend_code_val_q;
        pend_index_d     = pend_index_q;
        pend_index_val_d = pend_index_val_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef CMD_ENCODER_PENDING_EN
                if (pend_code_q) begin
                    start_go      = 1'b1;
                    start_is_code = 1'b1;
                    start_code    = pend_code_val_q;
                    pend_code_d   = 1'b0;
                end else if (bus.iCode_Send) begin
                    start_go      = 1'b1;
                    start_is_code = 1'b1;
                    code_taken    = 1'b1;
                end else if (pend_index_q) begin
                    start_go      = 1'b1;
                    start_index   = pend_index_val_q;
                    pend_index_d  = 1'b0;
                end else if (bus.iIndex_Send) begin
                    start_go      = 1'b1;
                    index_taken   = 1'b1;
                end
`else
                if (bus.iCode_Send) begin
                    start_go      = 1'b1;
                    start_is_code = 1'b1;
                    code_taken    = 1'b1;
                end else if (bus.iIndex_Send) begin
                    start_go      = 1'b1;
                    index_taken   = 1'b1;
                end
`endif
            end
            SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    phase_d = 8'd0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    phase_d = 8'd0;
                    state_d = LOW;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = 8'd0;
                    if (byte_q == (is_code_q ? 3'd4 : 3'd1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        data_d  = frame_byte(is_code_q, byte_q + 3'd1, code_q, index_q);
                        state_d = SETUP;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_go) begin
            state_d   = SETUP;
            phase_d   = 8'd0;
            byte_d    = 3'd0;
            is_code_d = start_is_code;
            data_d    = start_is_code ? 8'h01 : 8'h02;
            if (start_is_code) code_d = start_code;
            else               index_d = start_index;
        end

        // Requests not started this cycle either park in their slot or are dropped.
`ifdef CMD_ENCODER_PENDING_EN
        if (bus.iCode_Send && !code_taken) begin
            reject_d        = reject_d | pend_code_d;
            pend_code_d     = 1'b1;
            pend_code_val_d = bus.iCode;
        end
        if (bus.iIndex_Send && !index_taken) begin
            reject_d         = reject_d | pend_index_d;
            pend_index_d     = 1'b1;
            pend_index_val_d = bus.iIndex;
        end
`else
        if ((bus.iCode_Send && !code_taken) || (bus.iIndex_Send && !index_taken)) begin
            reject_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            phase_q   <= 8'd0;
            byte_q    <= 3'd0;
            data_q    <= 8'h00;
            code_q    <= 32'd0;
            index_q   <= 8'd0;
            is_code_q <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            code_q    <= code_d;
            index_q   <= index_d;
            is_code_q <= is_code_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

`ifdef CMD_ENCODER_PENDING_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pend_code_q      <= 1'b0;
            pend_code_val_q  <= 32'd0;
            pend_index_q     <= 1'b0;
            pend_index_val_q <= 8'd0;
        end else begin
            pend_code_q      <= pend_code_d;
            pend_code_val_q  <= pend_code_val_d;
            pend_index_q     <= pend_index_d;
            pend_index_val_q <= pend_index_val_d;
        end
    end
`endif

    assign bus.omData       = data_q;
    assign bus.omData_Ready = (state_q == HIGH);
    assign bus.oBusy        = (state_q != IDLE);
    assign bus.oDone        = done_q;
    assign bus.oReject      = reject_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// Scoreboard bench for cmd_encoder: a transaction-level model predicts byte strobes,
// done and reject pulses; an independent monitor pops and compares them.
module tb_cmd_encoder;

    localparam int P_SETUP = 3;
    localparam int P_HI    = 1;
    localparam int P_LO    = 4;
    localparam int P_BYTE  = P_SETUP + P_HI + P_LO;

    logic iClk;
    logic iRst_n;

    cmd_encoder_if bus();

    cmd_encoder #(
        .SETUP_CYC(P_SETUP),
        .STROBE_HI(P_HI),
        .STROBE_LO(P_LO)
    ) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .bus   (bus)
    );

    typedef struct { logic [7:0] val; int rise; } byte_ev_t;
    typedef struct { int at; int len; } done_ev_t;

    byte_ev_t exp_bytes[$];
    done_ev_t exp_done[$];
    int       exp_rej[$];

    int          cyc;
    int          free_at;
    int          n_cmp;
    int          n_err;
    bit          mon_en;
    bit          pc_v;
    bit          pi_v;
    logic [31:0] pc_p;
    logic [7:0]  pi_p;

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge iClk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue every observable event of one frame accepted by the request driven at cycle k.
    task automatic startFrame(input bit is_code, input logic [31:0] code, input logic [7:0] idx,
                              input int k);
        logic [7:0] bytes[$];
        int e;
        byte_ev_t be;
        done_ev_t de;
        e = k + 1;
        if (is_code) bytes = '{8'h01, code[7:0], code[15:8], code[23:16], code[31:24]};
        else         bytes = '{8'h02, idx};
        foreach (bytes[j]) begin
            be.val  = bytes[j];
            be.rise = e + j * P_BYTE + P_SETUP;
            exp_bytes.push_back(be);
        end
        de.at  = e + bytes.size() * P_BYTE;
        de.len = bytes.size() * P_BYTE;
        exp_done.push_back(de);
        free_at = de.at;
    endtask

    // Drive one cycle of requests and apply the encoder's acceptance rules to the model.
    task automatic applyStimulus(input logic cs, input logic [31:0] cv,
                                 input logic is, input logic [7:0] iv);
        int k;
        bit rej, cs_used, is_used;
        @(negedge iClk);
        bus.iCode       = cv;
        bus.iCode_Send  = cs;
        bus.iIndex      = iv;
        bus.iIndex_Send = is;
        k       = cyc;
        rej     = 1'b0;
        cs_used = 1'b0;
        is_used = 1'b0;
        if (k >= free_at) begin
`ifdef CMD_ENCODER_PENDING_EN
            if (pc_v) begin
                startFrame(1'b1, pc_p, 8'd0, k);
                pc_v = 1'b0;
            end else if (cs) begin
                startFrame(1'b1, cv, 8'd0, k);
                cs_used = 1'b1;
            end else if (pi_v) begin
                startFrame(1'b0, 32'd0, pi_p, k);
                pi_v = 1'b0;
            end else if (is) begin
                startFrame(1'b0, 32'd0, iv, k);
                is_used = 1'b1;
            end
`else
            if (cs) begin
                startFrame(1'b1, cv, 8'd0, k);
                cs_used = 1'b1;
            end else if (is) begin
                startFrame(1'b0, 32'd0, iv, k);
                is_used = 1'b1;
            end
`endif
        end
`ifdef CMD_ENCODER_PENDING_EN
        if (cs && !cs_used) begin
            if (pc_v) rej = 1'b1;
            pc_v = 1'b1;
            pc_p = cv;
        end
        if (is && !is_used) begin
            if (pi_v) rej = 1'b1;
            pi_v = 1'b1;
            pi_p = iv;
        end
`else
        if ((cs && !cs_used) || (is && !is_used)) rej = 1'b1;
`endif
        if (rej) exp_rej.push_back(k + 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((cyc <= free_at + 2 || pc_v || pi_v) && t < 3000) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 8'd0);
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_err++;
            $display("[TB] FAIL drain_bound: model still busy after %0d cycles", t);
        end
    endtask

    // Monitor: reacts only to what the DUT presents and pops the matching expectation.
    initial begin
        bit       prev_ready;
        int       busy_run;
        byte_ev_t cur;
        byte_ev_t be;
        done_ev_t de;
        int       rj;
        prev_ready = 1'b0;
        busy_run   = 0;
        cur.val    = 8'd0;
        cur.rise   = 0;
        forever begin
            @(negedge iClk);
            if (!mon_en) begin
                prev_ready = 1'b0;
                busy_run   = 0;
            end else begin
                if (bus.omData_Ready && !prev_ready) begin
                    if (exp_bytes.size() == 0) begin
                        checkOutput("byte_unexpected", 32'(bus.omData), 32'hFFFF_FFFF);
                    end else begin
                        be = exp_bytes.pop_front();
                        checkOutput("byte_value", 32'(bus.omData), 32'(be.val));
                        checkOutput("byte_time", 32'(cyc), 32'(be.rise));
                        cur = be;
                    end
                end
                if (!bus.omData_Ready && prev_ready) begin
                    checkOutput("strobe_fall_time", 32'(cyc), 32'(cur.rise + P_HI));
                    checkOutput("byte_hold", 32'(bus.omData), 32'(cur.val));
                end
                prev_ready = bus.omData_Ready;
                if (bus.oBusy) busy_run++;
                if (bus.oDone) begin
                    if (exp_done.size() == 0) begin
                        checkOutput("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        de = exp_done.pop_front();
                        checkOutput("done_time", 32'(cyc), 32'(de.at));
                        checkOutput("busy_cycles", 32'(busy_run), 32'(de.len));
                        checkOutput("busy_in_done", 32'(bus.oBusy), 32'd0);
                    end
                    busy_run = 0;
                end else if (!bus.oBusy) begin
                    busy_run = 0;
                end
                if (bus.oReject) begin
                    if (exp_rej.size() == 0) begin
                        checkOutput("reject_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        rj = exp_rej.pop_front();
                        checkOutput("reject_time", 32'(cyc), 32'(rj));
                    end
                end
            end
        end
    end

    initial begin
        logic cs;
        logic is;
        int   rises;
        bit   prev;
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        pc_v = 1'b0;
        pi_v = 1'b0;
        pc_p = 32'd0;
        pi_p = 8'd0;
        free_at = 0;
        bus.iCode = 32'd0;
        bus.iCode_Send = 1'b0;
        bus.iIndex = 8'd0;
        bus.iIndex_Send = 1'b0;
        iRst_n = 1'b0;
        #1;
        checkOutput("reset_data", 32'(bus.omData), 32'd0);
        checkOutput("reset_ready", 32'(bus.omData_Ready), 32'd0);
        checkOutput("reset_busy", 32'(bus.oBusy), 32'd0);
        checkOutput("reset_done", 32'(bus.oDone), 32'd0);
        checkOutput("reset_reject", 32'(bus.oReject), 32'd0);
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        free_at = cyc;
        mon_en = 1'b1;

        $display("[TB] directed frames");
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 8'd0);
        repeat (10) applyStimulus(1'b0, 32'd0, 1'b0, 8'd0);
        applyStimulus(1'b1, 32'h12345678, 1'b0, 8'd0);
        drain();
        applyStimulus(1'b1, 32'h00000001, 1'b1, 8'h07);
        drain();
        applyStimulus(1'b0, 32'd0, 1'b1, 8'h5A);
        applyStimulus(1'b0, 32'd0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 32'd0, 1'b1, 8'h33);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            cs = ($urandom_range(0, 11) == 0);
            is = ($urandom_range(0, 7) == 0);
            applyStimulus(cs, $urandom(), is, 8'($urandom()));
        end
        drain();

        $display("[TB] reset mid-frame");
        mon_en = 1'b0;
        @(negedge iClk);
        bus.iCode = 32'hCAFE0123;
        bus.iCode_Send = 1'b1;
        @(negedge iClk);
        bus.iCode_Send = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int t = 0; t < 200 && rises < 3; t++) begin
            @(negedge iClk);
            if (bus.omData_Ready && !prev) rises++;
            prev = bus.omData_Ready;
        end
        checkOutput("third_strobe_seen", 32'(rises), 32'd3);
        #2 iRst_n = 1'b0;
        #1;
        checkOutput("abort_data", 32'(bus.omData), 32'd0);
        checkOutput("abort_ready", 32'(bus.omData_Ready), 32'd0);
        checkOutput("abort_busy", 32'(bus.oBusy), 32'd0);
        checkOutput("abort_done", 32'(bus.oDone), 32'd0);
        checkOutput("abort_reject", 32'(bus.oReject), 32'd0);
        repeat (3) begin
            @(negedge iClk);
            checkOutput("abort_no_done", 32'(bus.oDone), 32'd0);
        end
        @(negedge iClk);
        exp_bytes.delete();
        exp_done.delete();
        exp_rej.delete();
        pc_v = 1'b0;
        pi_v = 1'b0;
        iRst_n = 1'b1;
        free_at = cyc;
        mon_en = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 8'h3C);
        for (int i = 0; i < 150; i++) begin
            cs = ($urandom_range(0, 9) == 0);
            is = ($urandom_range(0, 9) == 0);
            applyStimulus(cs, $urandom(), is, 8'($urandom()));
        end
        drain();

        checkOutput("bytes_left", 32'(exp_bytes.size()), 32'd0);
        checkOutput("done_left", 32'(exp_done.size()), 32'd0);
        checkOutput("reject_left", 32'(exp_rej.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_encoder.md
CMD_ENCODER -- requirements
Module: cmd_encoder

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles omData is stable with omData_Ready low before each strobe; legal range 1..255.
REQ-002 SHALL have parameter STROBE_HI, default 2: cycles omData_Ready is held high per byte; legal range 1..255.
REQ-003 SHALL have parameter STROBE_LO, default 2: cycles omData_Ready is held low after each strobe, with omData still held; legal range 1..255.
REQ-004 SHALL have port iClk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port iRst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port iCode, input, 32: code word to send.
REQ-007 SHALL have port iCode_Send, input, 1: one-cycle request to send a code frame.
REQ-008 SHALL have port iIndex, input, 8: index byte to send.
REQ-009 SHALL have port iIndex_Send, input, 1: one-cycle request to send an index frame.
REQ-010 SHALL have port omData, output, 8: byte on the link.
REQ-011 SHALL have port omData_Ready, output, 1: byte strobe; the receiver samples on the rising edge and advances on the falling edge.
REQ-012 SHALL have port oBusy, output, 1: high while a frame is in transmission.
REQ-013 SHALL have port oDone, output, 1: one-cycle pulse when a frame completes.
REQ-014 SHALL have port oReject, output, 1: one-cycle pulse when a request is dropped.

Function
REQ-015 A code frame SHALL be 5 bytes: 0x01, iCode[7:0], iCode[15:8], iCode[23:16], iCode[31:24].
REQ-016 An index frame SHALL be 2 bytes: 0x02, iIndex.
REQ-017 Payload SHALL be captured into internal registers in the cycle its request is accepted; later input changes SHALL NOT affect the frame in flight.
REQ-018 The FSM SHALL have states IDLE, SETUP, HIGH, LOW, and transition IDLE->SETUP->HIGH->LOW, then ->SETUP for the next byte or ->IDLE after the last byte.
REQ-019 A request seen in IDLE SHALL be accepted; in the next cycle the FSM SHALL be in SETUP, with omData = command byte and oBusy = 1.
REQ-020 omData SHALL change only on entry to SETUP and SHALL be held through SETUP, HIGH and LOW.
REQ-021 omData_Ready SHALL be 1 only in HIGH; each byte SHALL take exactly SETUP_CYC+STROBE_HI+STROBE_LO cycles.
REQ-022 The phase counter SHALL be 8 bits and the byte counter 3 bits; both SHALL reload to 0 on each phase or frame start.
REQ-023 In the cycle after the last LOW cycle, the FSM SHALL be in IDLE with oBusy = 0 and oDone = 1, and a new request SHALL be acceptable in that same cycle.
REQ-024 If iCode_Send and iIndex_Send are both high in IDLE, the code frame SHALL win.
REQ-025 Without the pending option, a losing simultaneous request, or any request while oBusy = 1, SHALL be dropped with oReject = 1 in the following cycle.

Reset
REQ-026 iRst_n low SHALL immediately force IDLE and clear all counters, captured payloads and pending flags.
REQ-027 During reset, omData SHALL be 0x00 and omData_Ready, oBusy, oDone and oReject SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no oDone; operation SHALL resume in IDLE on the first clock edge after iRst_n is released.

Configuration
REQ-029 With macro CMD_ENCODER_PENDING_EN defined, the block SHALL keep one pending slot per frame type, holding the flag and captured payload.
REQ-030 With the macro defined, a request arriving while busy or losing arbitration SHALL fill its slot, and no oReject SHALL be raised.
REQ-031 With the macro defined, a request for an already-full slot SHALL overwrite the slot payload and pulse oReject.
REQ-032 With the macro defined, in the oDone cycle a pending code frame SHALL start before a pending index frame, with SETUP in the next cycle.
REQ-033 Without the macro, behaviour SHALL be exactly REQ-025 and no pending storage SHALL exist.

Verification
REQ-034 Code frame, default parameters: iCode=0xDEADBEEF, 1-cycle iCode_Send -> bytes 0x01,0xEF,0xBE,0xAD,0xDE; 5 strobes each 2 cycles high; 25 busy cycles; then oDone.
REQ-035 Index frame, SETUP_CYC=3, STROBE_HI=1, STROBE_LO=4: iIndex=0x5A -> bytes 0x02,0x5A; 16 busy cycles; omData constant from each SETUP through its LOW.
REQ-036 Simultaneous requests, macro undefined: iCode=0x00000001 and iIndex=0x07 together -> code frame only; oReject pulses once.
REQ-037 Same stimulus, macro defined -> code frame, then index frame starting the cycle after oDone; no oReject.
REQ-038 iRst_n low during the third strobe of a code frame -> all outputs 0 at once, no oDone; a fresh index request after release sends 0x02,iIndex correctly.
REQ-039 iCode_Send during a busy frame, macro undefined -> oReject pulse, and the bytes of the frame in flight are unchanged.
